apb2ahb_bridge: RTL and testbench

APB4 completer to AHB-Lite manager bridge. It lets an APB-side requester, such as a debug/config APB or a DMA control port, reach AHB slaves. Each APB access becomes exactly one single NONSEQ AHB transfer, or none for the special strobe cases below. Single clock domain (HCLK); APB PCLK is HCLK.

---
 rtl/apb2ahb_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_apb2ahb_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2ahb_bridge.sv
// APB4 completer to AHB-Lite manager bridge. Each APB access becomes one SINGLE
// NONSEQ AHB transfer; zero and illegal write strobes are answered without one.
module apb2ahb_bridge #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [ADDRWIDTH-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic [DATAWIDTH-1:0] HRDATA
);

    if (DATAWIDTH != 32) begin : gen_width_check
        $error("apb2ahb_bridge: only DATAWIDTH=32 is supported");
    end

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR2,
        ST_RESP
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDRWIDTH-1:0]   haddr_nxt;
    logic [1:0]             htrans_nxt;
    logic                   hwrite_nxt;
    logic [2:0]             hsize_nxt;
    logic [3:0]             hprot_nxt;
    logic [DATAWIDTH-1:0]   hwdata_nxt;
    logic [DATAWIDTH-1:0]   prdata_nxt;
    logic                   pready_nxt;
    logic                   pslverr_nxt;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_nxt;
    logic                   abort_q, abort_nxt;
    logic                   discard;

    logic                   strb_legal;
    logic [2:0]             strb_size;
    logic [1:0]             strb_lane;

    logic                   unused_bits;
    assign unused_bits = ^{PPROT[1], PADDR[1:0]};

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    // Only naturally aligned byte, halfword and word strobes map onto one AHB transfer.
    always_comb begin
        strb_legal = 1'b1;
        strb_size  = 3'b010;
        strb_lane  = 2'b00;
        case (PSTRB)
            4'b1111: strb_size = 3'b010;
            4'b0011: strb_size = 3'b001;
            4'b1100: begin strb_size = 3'b001; strb_lane = 2'b10; end
            4'b0001: strb_size = 3'b000;
            4'b0010: begin strb_size = 3'b000; strb_lane = 2'b01; end
            4'b0100: begin strb_size = 3'b000; strb_lane = 2'b10; end
            4'b1000: begin strb_size = 3'b000; strb_lane = 2'b11; end
            default: strb_legal = 1'b0;
        endcase
    end

    // A requester that dropped PSEL mid-transfer gets no response at all.
    assign discard = abort_q || !PSEL;

    always_comb begin
        state_nxt   = state;
        haddr_nxt   = HADDR;
        htrans_nxt  = HTRANS;
        hwrite_nxt  = HWRITE;
        hsize_nxt   = HSIZE;
        hprot_nxt   = HPROT;
        hwdata_nxt  = HWDATA;
        prdata_nxt  = PRDATA;
        pslverr_nxt = 1'b0;
        wdata_nxt   = wdata_q;
        abort_nxt   = abort_q;

        case (state)
            ST_IDLE: begin
                abort_nxt = 1'b0;
                if (PSEL && !PENABLE) begin
                    if (PWRITE && PSTRB == 4'b0000) begin
                        state_nxt = ST_RESP;
                    end else if (PWRITE && !strb_legal) begin
                        state_nxt   = ST_RESP;
                        pslverr_nxt = 1'b1;
                    end else begin
                        state_nxt  = ST_ADDR;
                        htrans_nxt = HTRANS_NONSEQ;
                        hwrite_nxt = PWRITE;
                        hprot_nxt  = {2'b00, PPROT[0], ~PPROT[2]};
                        wdata_nxt  = PWDATA;
                        if (PWRITE) begin
                            haddr_nxt = {PADDR[ADDRWIDTH-1:2], strb_lane};
                            hsize_nxt = strb_size;
                        end else begin
                            haddr_nxt = {PADDR[ADDRWIDTH-1:2], 2'b00};
                            hsize_nxt = 3'b010;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (!PSEL) abort_nxt = 1'b1;
                if (HREADY) begin
                    state_nxt  = ST_DATA;
                    htrans_nxt = HTRANS_IDLE;
                    if (HWRITE) hwdata_nxt = wdata_q;
                end
            end
            ST_DATA: begin
                if (!PSEL) abort_nxt = 1'b1;
                if (HRESP && !HREADY) begin
                    state_nxt = ST_ERR2;
                end else if (HREADY) begin
                    // A single-cycle ERROR is not legal AHB but is still reported as an error.
                    if (discard) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_RESP;
                        pslverr_nxt = HRESP;
                        if (!HWRITE) prdata_nxt = HRESP ? '0 : HRDATA;
                    end
                end
            end
            ST_ERR2: begin
                if (!PSEL) abort_nxt = 1'b1;
                if (HREADY) begin
                    if (discard) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_RESP;
                        pslverr_nxt = 1'b1;
                        if (!HWRITE) prdata_nxt = '0;
                    end
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt  = ST_IDLE;
                htrans_nxt = HTRANS_IDLE;
            end
        endcase

        pready_nxt = (state_nxt == ST_RESP);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            HADDR   <= '0;
            HTRANS  <= HTRANS_IDLE;
            HWRITE  <= 1'b0;
            HSIZE   <= 3'b010;
            HPROT   <= 4'b0011;
            HWDATA  <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            wdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            HADDR   <= haddr_nxt;
            HTRANS  <= htrans_nxt;
            HWRITE  <= hwrite_nxt;
            HSIZE   <= hsize_nxt;
            HPROT   <= hprot_nxt;
            HWDATA  <= hwdata_nxt;
            PRDATA  <= prdata_nxt;
            PREADY  <= pready_nxt;
            PSLVERR <= pslverr_nxt;
            wdata_q <= wdata_nxt;
            abort_q <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Self-checking bench for apb2ahb_bridge: the bench plays APB requester and AHB
// slave, and compares each access against a transaction-level reference model.
module tb_apb2ahb_bridge;

    logic        hclk;
    logic        hresetn;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    int vectors;
    int miscompares;

    // Observations collected while a transaction runs
    int          obs_nonseq;
    logic [15:0] obs_haddr;
    logic [2:0]  obs_hsize;
    logic        obs_hwrite;
    logic [3:0]  obs_hprot;
    logic [31:0] obs_hwdata;
    int          obs_lat;
    logic        obs_err;
    logic [31:0] obs_prdata;
    logic        obs_ready_after;

    logic [31:0] prdata_model;

    apb2ahb_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .HCLK(hclk), .HRESETn(hresetn),
        .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One APB access; the bench answers the AHB side with the requested waits/error.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot, input int wait_cycles,
                                 input logic err, input logic [31:0] rdata, input int abort_at);
        int cycles;
        int dcnt;
        bit done;
        bit in_data;
        obs_nonseq = 0;
        obs_lat    = -1;
        obs_err    = 1'b0;
        obs_prdata = '0;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        hready = 1'b1; hresp = 1'b0;
        cycles = 0; dcnt = 0; done = 0; in_data = 0;
        while (!done && cycles < 20) begin
            @(negedge hclk);
            cycles++;
            penable = 1'b1;
            if (abort_at != 0 && cycles >= abort_at) begin
                psel = 1'b0;
                penable = 1'b0;
            end
            if (pready) begin
                obs_lat    = cycles;
                obs_err    = pslverr;
                obs_prdata = prdata;
                done       = 1;
            end
            if (in_data) begin
                if (dcnt == 0) obs_hwdata = hwdata;
                if (dcnt < wait_cycles) begin
                    hready = 1'b0; hresp = 1'b0; hrdata = $urandom;
                end else if (err && dcnt == wait_cycles) begin
                    hready = 1'b0; hresp = 1'b1; hrdata = $urandom;
                end else begin
                    hready = 1'b1; hresp = err; hrdata = err ? $urandom : rdata;
                    in_data = 0;
                end
                dcnt++;
            end else begin
                hready = 1'b1; hresp = 1'b0;
            end
            if (htrans == 2'b10) begin
                obs_nonseq++;
                obs_haddr  = haddr;
                obs_hsize  = hsize;
                obs_hwrite = hwrite;
                obs_hprot  = hprot;
                in_data    = 1;
                dcnt       = 0;
            end
        end
        @(negedge hclk);
        obs_ready_after = pready;
        psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = 1'b0;
    endtask

    // Reference model: derive the expected AHB transfer and APB response from the access.
    task automatic runAndCheck(input string name, input logic wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                               input int wait_cycles, input logic err, input logic [31:0] rdata,
                               input int abort_at);
        bit         legal;
        bit         ahb;
        logic [2:0] esize;
        logic [1:0] elane;
        int         elat;
        logic       eerr;
        applyStimulus(wr, addr, wdata, strb, prot, wait_cycles, err, rdata, abort_at);

        legal = !wr;
        esize = 3'd2;
        elane = 2'd0;
        if (wr) begin
            for (int n = 1; n <= 4; n = n * 2)
                for (int off = 0; off < 4; off = off + n)
                    if (strb == 4'(((1 << n) - 1) << off)) begin
                        legal = 1;
                        esize = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
                        elane = 2'(off);
                    end
        end
        ahb = legal;
        if (ahb) begin
            elat = 3 + wait_cycles + (err ? 1 : 0);
            eerr = err;
        end else begin
            elat = 1;
            eerr = (strb != 4'b0000);
        end
        if (abort_at != 0 && ahb) elat = -1;
        if (ahb && !wr && abort_at == 0) prdata_model = err ? 32'h0 : rdata;

        checkOutput({name, ".nonseq"}, 32'(obs_nonseq), ahb ? 32'd1 : 32'd0);
        if (ahb) begin
            checkOutput({name, ".haddr"}, 32'(obs_haddr), 32'({addr[15:2], elane}));
            checkOutput({name, ".hsize"}, 32'(obs_hsize), 32'(esize));
            checkOutput({name, ".hwrite"}, 32'(obs_hwrite), 32'(wr));
            checkOutput({name, ".hprot"}, 32'(obs_hprot), 32'({2'b00, prot[0], ~prot[2]}));
            if (wr) checkOutput({name, ".hwdata"}, obs_hwdata, wdata);
        end
        checkOutput({name, ".latency"}, 32'(obs_lat), 32'(elat));
        if (elat > 0) begin
            checkOutput({name, ".pslverr"}, 32'(obs_err), 32'(eerr));
            if (!wr) checkOutput({name, ".prdata_resp"}, obs_prdata, prdata_model);
        end
        checkOutput({name, ".pready_after"}, 32'(obs_ready_after), 32'd0);
        checkOutput({name, ".prdata_hold"}, prdata, prdata_model);
    endtask

    initial begin
        logic [3:0] legal_tab [7];
        logic       r_wr;
        logic [3:0] r_strb;
        vectors = 0;
        miscompares = 0;
        legal_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        hresetn = 1'b0;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; pprot = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        prdata_model = '0;
        repeat (3) @(negedge hclk);

        checkOutput("reset.htrans", 32'(htrans), 32'd0);
        checkOutput("reset.haddr", 32'(haddr), 32'd0);
        checkOutput("reset.hwrite", 32'(hwrite), 32'd0);
        checkOutput("reset.hsize", 32'(hsize), 32'd2);
        checkOutput("reset.hprot", 32'(hprot), 32'h3);
        checkOutput("reset.hwdata", hwdata, 32'd0);
        checkOutput("reset.prdata", prdata, 32'd0);
        checkOutput("reset.pready", 32'(pready), 32'd0);
        checkOutput("reset.pslverr", 32'(pslverr), 32'd0);
        checkOutput("reset.hburst", 32'(hburst), 32'd0);
        checkOutput("reset.hmastlock", 32'(hmastlock), 32'd0);
        hresetn = 1'b1;
        @(negedge hclk);
        $display("[TB] reset released, starting directed accesses");

        runAndCheck("wr_word", 1'b1, 16'h0104, 32'hDEADBEEF, 4'b1111, 3'b000, 0, 1'b0, 32'h0, 0);
        runAndCheck("wr_b2b", 1'b1, 16'h0108, 32'hCAFEF00D, 4'b1111, 3'b101, 0, 1'b0, 32'h0, 0);
        runAndCheck("rd_wait2", 1'b0, 16'h0208, 32'h0, 4'b0000, 3'b001, 2, 1'b0, 32'h12345678, 0);
        runAndCheck("wr_byte", 1'b1, 16'h0013, 32'h00AB0000, 4'b0100, 3'b010, 0, 1'b0, 32'h0, 0);
        runAndCheck("wr_badstrb", 1'b1, 16'h0020, 32'h11111111, 4'b0101, 3'b000, 0, 1'b0, 32'h0, 0);
        runAndCheck("wr_nostrb", 1'b1, 16'h0024, 32'h22222222, 4'b0000, 3'b000, 0, 1'b0, 32'h0, 0);
        runAndCheck("rd_error", 1'b0, 16'h0300, 32'h0, 4'b1111, 3'b000, 0, 1'b1, 32'h0, 0);
        runAndCheck("rd_fill", 1'b0, 16'h0304, 32'h0, 4'b0000, 3'b000, 1, 1'b0, 32'h5A5A1234, 0);
        runAndCheck("rd_abort", 1'b0, 16'h0308, 32'h0, 4'b0000, 3'b000, 3, 1'b0, 32'h99998888, 2);
        runAndCheck("wr_half", 1'b1, 16'h0042, 32'hBEEF0000, 4'b1100, 3'b111, 1, 1'b0, 32'h0, 0);
        runAndCheck("wr_error", 1'b1, 16'h0050, 32'h0000CAFE, 4'b0011, 3'b100, 1, 1'b1, 32'h0, 0);

        // Reset asserted while a read sits in its data phase
        psel = 1'b1; penable = 1'b0; paddr = 16'h0208; pwrite = 1'b0; pstrb = 4'b0000;
        hready = 1'b1; hresp = 1'b0;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        hready = 1'b0;
        hresetn = 1'b0;
        #1;
        checkOutput("rst_mid.htrans", 32'(htrans), 32'd0);
        checkOutput("rst_mid.pready", 32'(pready), 32'd0);
        checkOutput("rst_mid.haddr", 32'(haddr), 32'd0);
        checkOutput("rst_mid.hsize", 32'(hsize), 32'd2);
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0; hready = 1'b1;
        hresetn = 1'b1;
        prdata_model = '0;
        @(negedge hclk);
        runAndCheck("rd_after_rst", 1'b0, 16'h0400, 32'h0, 4'b0000, 3'b000, 0, 1'b0, 32'h0BADF00D, 0);

        $display("[TB] starting randomized accesses");
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_strb = ($urandom_range(0, 3) != 0) ? legal_tab[$urandom_range(0, 6)] : 4'($urandom);
            runAndCheck($sformatf("rand%0d", i), r_wr, 16'($urandom), $urandom, r_strb,
                        3'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                        $urandom, 0);
            if ($urandom_range(0, 3) == 0) @(negedge hclk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
